// File: rtl/quad_dec_oci_pkg.sv
// Shared constants and types for the CPU OCI trace-buffer controller.
// ATOM_W : bits per trace atom
// SLOTS  : atoms per frame
// BUF_W  : packed frame width (ATOM_W*SLOTS)
// CNT_W  : slot-counter width (2**CNT_W > SLOTS)
package quad_dec_oci_pkg;

  localparam int ATOM_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = 30;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [BUF_W-1:0] data;
    logic [CNT_W-1:0] count;
  } frame_t;

endpackage

// File: rtl/quad_dec_cpu_oci_dct_ctrl_if.sv
// Handshake bundle for the trace-buffer controller.
// Atom side : atom_valid/atom in, atom_ready out (producer -> controller).
// Frame side: frame_valid/frame_data/frame_count out, frame_ready in
//             (controller -> trace store).
// slave modport is the controller's view; master is the environment's.
interface quad_dec_cpu_oci_dct_ctrl_if;
  import quad_dec_oci_pkg::*;

  logic              atom_valid;
  logic [ATOM_W-1:0] atom;
  logic              atom_ready;
  logic              frame_valid;
  logic [BUF_W-1:0]  frame_data;
  logic [CNT_W-1:0]  frame_count;
  logic              frame_ready;

  modport master (
    output atom_valid, atom, frame_ready,
    input  atom_ready, frame_valid, frame_data, frame_count
  );

  modport slave (
    input  atom_valid, atom, frame_ready,
    output atom_ready, frame_valid, frame_data, frame_count
  );

endinterface

// File: rtl/quad_dec_oci_frame_reg.sv
// Single-entry valid/ready holding register for completed trace frames.
// clk, reset_n : clock, asynchronous active-low reset
// load         : capture load_frame this edge (caller guarantees the slot is
//                free or being emptied this cycle)
// load_frame   : frame to capture
// out_ready    : consumer takes out_frame when out_valid is high
// out_valid    : holding register occupied
// out_frame    : held frame, stable while out_valid && !out_ready
module quad_dec_oci_frame_reg
  import quad_dec_oci_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  frame_t load_frame,
  input  logic   out_ready,
  output logic   out_valid,
  output frame_t out_frame
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_frame <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_frame <= load_frame;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/quad_dec_cpu_oci_dct_ctrl.sv
// Trace-buffer controller for the CPU OCI debug path. Packs 2-bit atoms into
// a 15-slot live buffer, hands full or flushed frames to the trace store and
// sequences the end-of-test drain.
// clk, reset_n   : clock, asynchronous active-low reset
// bus (slave)    : atom valid/ready input, frame valid/ready output
// flush_req      : single-cycle request to emit the partial buffer
// test_ending    : level, starts the end-of-test drain
// dct_buffer     : live fill buffer (unused slots read 0)
// dct_count      : live slot count, 0..SLOTS-1
// test_has_ended : drain complete, sticky until reset
//
// state | meaning
// RUN   | accepting atoms, frames emitted on full or flush
// DRAIN | atoms blocked, partial buffer flushed, waiting for store to take it
// DONE  | test_has_ended high, everything ignored until reset
module quad_dec_cpu_oci_dct_ctrl
  import quad_dec_oci_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  quad_dec_cpu_oci_dct_ctrl_if.slave bus,
  input  logic                      flush_req,
  input  logic                      test_ending,
  output logic [BUF_W-1:0]          dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      test_has_ended
);

  if (BUF_W != ATOM_W * SLOTS) begin : g_bad_buf_w
    $error("BUF_W must equal ATOM_W*SLOTS");
  end
  if ((1 << CNT_W) <= SLOTS) begin : g_bad_cnt_w
    $error("CNT_W too narrow for SLOTS");
  end

  state_t           state;
  logic             flush_pending;
  logic             at_last;
  logic             accept;
  logic             load_free;
  logic             full;
  logic             flush_exec;
  logic             flush_clear_empty;
  logic             flush_req_eff;
  logic             load;
  logic [BUF_W-1:0] merged;
  frame_t           load_frame;
  frame_t           held_frame;

  assign at_last = (dct_count == CNT_W'(SLOTS - 1));

  // Last slot stalls while a frame is still held, since completing the
  // buffer would need the holding register.
  assign bus.atom_ready = (state == RUN) && !(bus.frame_valid && at_last);

  assign accept     = bus.atom_valid && bus.atom_ready;
  assign load_free  = !bus.frame_valid || bus.frame_ready;
  assign full       = accept && at_last;
  assign flush_exec = flush_pending && load_free && ((dct_count != '0) || accept);
  // Pending flush with nothing to send simply retires.
  assign flush_clear_empty = flush_pending && (dct_count == '0) && !accept;
  assign flush_req_eff     = flush_req && (state == RUN);
  assign load              = full || flush_exec;

  always_comb begin
    merged = dct_buffer;
    if (accept) begin
      merged[ATOM_W*dct_count +: ATOM_W] = bus.atom;
    end
  end

  always_comb begin
    load_frame.data  = merged;
    load_frame.count = full ? CNT_W'(SLOTS) : dct_count + CNT_W'(accept);
  end

  quad_dec_oci_frame_reg u_frame_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_frame (load_frame),
    .out_ready  (bus.frame_ready),
    .out_valid  (bus.frame_valid),
    .out_frame  (held_frame)
  );

  assign bus.frame_data  = held_frame.data;
  assign bus.frame_count = held_frame.count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      dct_buffer     <= '0;
      dct_count      <= '0;
      flush_pending  <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      if (load) begin
        dct_buffer <= '0;
        dct_count  <= '0;
      end else if (accept) begin
        dct_buffer <= merged;
        dct_count  <= dct_count + CNT_W'(1);
      end

      // A full frame satisfies any flush raised alongside it.
      if (full) begin
        flush_pending <= 1'b0;
      end else if (flush_exec || flush_clear_empty) begin
        flush_pending <= flush_req_eff;
      end else if (flush_req_eff) begin
        flush_pending <= 1'b1;
      end

      case (state)
        RUN: begin
          if (test_ending) begin
            state         <= DRAIN;
            flush_pending <= 1'b1;
          end
        end
        DRAIN: begin
          if (!flush_pending && !bus.frame_valid) begin
            state          <= DONE;
            test_has_ended <= 1'b1;
          end
        end
        DONE: begin
          test_has_ended <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
